nios_system_sram_datain: RTL and testbench

NIOS_SYSTEM_SRAM_DATAIN -- requirements
Module: nios_system_sram_datain

---
 rtl/nios_system_pio_pkg.sv | 13 +
 rtl/nios_system_sync2.sv | 25 ++
 rtl/nios_system_sram_datain.sv | 101 ++++++++++
 tb/tb_nios_system_sram_datain.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_pio_pkg.sv
// Register map and edge-select encodings shared by the PIO-style input ports.
package nios_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_system_sync2.sv
// Parameterised-width two-flop synchronizer for asynchronous pin inputs.
module nios_system_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/nios_system_sram_datain.sv
// Avalon-MM input port for the SRAM data bus: synchronized data, edge capture
// and optional masked interrupt (enabled by defining SRAM_DATAIN_IRQ_EN).
module nios_system_sram_datain
  import nios_system_pio_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int EDGE_TYPE = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic              irq
);

  logic [DATA_W-1:0] sync_val;
  logic [DATA_W-1:0] sync_d1_q, sync_d1_d;
  logic [DATA_W-1:0] edgecap_q, edgecap_d;
  logic [DATA_W-1:0] edge_det, clr_bits, mask_val;
  logic [31:0]       readdata_q, readdata_d, rd_mux;
  logic              rd_en, wr_en;
  logic              unused_wd;

  // Bits of writedata above DATA_W carry no state.
  assign unused_wd = ^writedata;

  nios_system_sync2 #(.W(DATA_W)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync_val)
  );

  always_comb begin
    rd_en     = chipselect & ~read_n;
    wr_en     = chipselect & ~write_n;
    sync_d1_d = sync_val;
    case (EDGE_TYPE)
      EDGE_RISE: edge_det = sync_val & ~sync_d1_q;
      EDGE_FALL: edge_det = ~sync_val & sync_d1_q;
      default:   edge_det = sync_val ^ sync_d1_q;
    endcase
    clr_bits  = (wr_en && address == ADDR_EDGECAP) ? writedata[DATA_W-1:0] : '0;
    // A new edge overrides a same-cycle clear of that bit.
    edgecap_d = (edgecap_q & ~clr_bits) | edge_det;
    rd_mux    = '0;
    case (address)
      ADDR_DATA:    rd_mux[DATA_W-1:0] = sync_val;
      ADDR_IRQMASK: rd_mux[DATA_W-1:0] = mask_val;
      ADDR_EDGECAP: rd_mux[DATA_W-1:0] = edgecap_q;
      default:      rd_mux = '0;
    endcase
    readdata_d = rd_en ? rd_mux : readdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_d1_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      sync_d1_q  <= sync_d1_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

`ifdef SRAM_DATAIN_IRQ_EN
  logic [DATA_W-1:0] irqmask_q, irqmask_d;
  logic              irq_q, irq_d;

  always_comb begin
    irqmask_d = (wr_en && address == ADDR_IRQMASK) ? writedata[DATA_W-1:0] : irqmask_q;
    irq_d     = |(edgecap_q & irqmask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      irqmask_q <= irqmask_d;
      irq_q     <= irq_d;
    end
  end

  assign mask_val = irqmask_q;
  assign irq      = irq_q;
`else
  assign mask_val = '0;
  assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_nios_system_sram_datain.sv
// Self-checking bench: directed register/latency/reset checks, then random bus
// and pin traffic compared each cycle against a delay-line reference model.
module tb_nios_system_sram_datain;

  localparam int DW     = 16;
  localparam int EDGE_T = 0;

  logic          clk, reset_n;
  logic [1:0]    address;
  logic          chipselect, read_n, write_n;
  logic [31:0]   writedata, readdata, rv;
  logic [DW-1:0] in_port;
  logic          irq;

  int n_chk = 0;
  int n_fail = 0;

  nios_system_sram_datain #(.DATA_W(DW), .EDGE_TYPE(EDGE_T)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pins pass through a 2-deep delay line; the value seen two
  // samples ago is the synchronized value, three samples ago is its predecessor.
  logic [DW-1:0] dl [3];
  logic [DW-1:0] m_cap, m_mask, ev, clr, n_cap, n_mask;
  logic [31:0]   m_rd, n_rd;
  logic          m_irq;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) dl[i] = '0;
      m_cap = '0; m_mask = '0; m_rd = '0; m_irq = 1'b0;
    end else begin
      for (int b = 0; b < DW; b++) begin
        case (EDGE_T)
          0:       ev[b] = dl[1][b] && !dl[2][b];
          1:       ev[b] = !dl[1][b] && dl[2][b];
          default: ev[b] = dl[1][b] != dl[2][b];
        endcase
      end
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[DW-1:0] : '0;
      n_cap = (m_cap & ~clr) | ev;
      n_mask = m_mask;
`ifdef SRAM_DATAIN_IRQ_EN
      if (chipselect && !write_n && address == 2'd2) n_mask = writedata[DW-1:0];
`endif
      n_rd = m_rd;
      if (chipselect && !read_n) begin
        case (address)
          2'd0:    n_rd = 32'(dl[1]);
          2'd2:    n_rd = 32'(m_mask);
          2'd3:    n_rd = 32'(m_cap);
          default: n_rd = 32'd0;
        endcase
      end
      m_irq  = (m_cap & m_mask) != '0;
      m_cap  = n_cap;
      m_mask = n_mask;
      m_rd   = n_rd;
      dl[2]  = dl[1];
      dl[1]  = dl[0];
      dl[0]  = in_port;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    writedata = '0; in_port = '0;
    repeat (2) tick();
    chk("rst_rd", readdata, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;

    // Synchronized data read, then the rising edges it produced from reset zeros
    in_port = 16'hA5C3;
    repeat (4) tick();
    bus_rd(2'd0, rv); chk("data_rd", rv, 32'h0000A5C3);
    bus_rd(2'd3, rv); chk("cap_initial", rv, 32'h0000A5C3);
    bus_wr(2'd3, 32'hFFFF_FFFF);
    bus_rd(2'd3, rv); chk("cap_clr_all", rv, 32'h0);

    // Falling edges ignored; rising edge on bit3 lands on the third clock edge
    in_port = 16'h0000;
    repeat (4) tick();
    bus_rd(2'd3, rv); chk("fall_ignored", rv, 32'h0);
    in_port = 16'h0008;
    tick(); tick();
    address = 2'd3; chipselect = 1'b1; read_n = 1'b0;
    tick(); chk("cap_edge3_pre", readdata, 32'h0);
    tick(); chk("cap_edge3_set", readdata, 32'h0000_0008);
    chipselect = 1'b0; read_n = 1'b1;
    in_port = 16'h0000;
    repeat (5) tick();
    bus_rd(2'd3, rv); chk("cap_sticky", rv, 32'h0000_0008);

`ifdef SRAM_DATAIN_IRQ_EN
    bus_wr(2'd3, 32'h8);
    bus_wr(2'd2, 32'hFFFF_0008);
    bus_rd(2'd2, rv); chk("mask_rd", rv, 32'h0000_0008);
    chk("irq_idle", {31'd0, irq}, 32'h0);
    in_port = 16'h0008;
    repeat (3) tick(); chk("irq_edge3", {31'd0, irq}, 32'h0);
    tick();            chk("irq_edge4", {31'd0, irq}, 32'h1);
    bus_wr(2'd3, 32'h8); chk("irq_hold", {31'd0, irq}, 32'h1);
    tick();              chk("irq_clr", {31'd0, irq}, 32'h0);
`else
    bus_wr(2'd2, 32'h0000_FFFF);
    bus_rd(2'd2, rv); chk("mask_absent", rv, 32'h0);
    in_port = 16'h0008;
    repeat (5) tick(); chk("irq_tied", {31'd0, irq}, 32'h0);
    bus_rd(2'd3, rv);  chk("cap_poll", rv, 32'h0000_0008);
    bus_wr(2'd3, 32'h8);
`endif

    // Edge on bit0 in the same cycle as its clear: the capture survives
    in_port = 16'h0009;
    tick(); tick();
    bus_wr(2'd3, 32'h1);
    bus_rd(2'd3, rv); chk("set_wins", rv, 32'h0000_0001);
    bus_wr(2'd3, 32'h1);
    bus_rd(2'd3, rv); chk("w1c", rv, 32'h0);

    bus_wr(2'd0, 32'hFFFF_FFFF);
    bus_wr(2'd1, 32'hFFFF_FFFF);
    bus_rd(2'd1, rv); chk("rsvd_rd", rv, 32'h0);
    bus_rd(2'd0, rv); chk("data_ro", rv, 32'h0000_0009);

`ifdef SRAM_DATAIN_IRQ_EN
    in_port = 16'h0001;
    repeat (4) tick();
    in_port = 16'h0009;
    repeat (5) tick(); chk("irq_pre_rst", {31'd0, irq}, 32'h1);
    bus_rd(2'd2, rv);  chk("mask_pre_rst", rv, 32'h0000_0008);
`else
    bus_rd(2'd0, rv);  chk("data_pre_rst", rv, 32'h0000_0009);
`endif
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_irq", {31'd0, irq}, 32'h0);
    chk("rst_async_rd", readdata, 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    // Pins already high at release are seen as rising edges once synchronized
    repeat (4) tick();
    bus_rd(2'd3, rv); chk("cap_after_rst", rv, 32'h0000_0009);
    bus_rd(2'd2, rv); chk("mask_after_rst", rv, 32'h0);

    for (int c = 0; c < 600; c++) begin
      chk("rnd_rd", readdata, m_rd);
      chk("rnd_irq", {31'd0, irq}, {31'd0, m_irq});
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      read_n     = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      if ($urandom_range(0, 2) == 0) in_port = DW'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
